// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, bit-period counter width and the default baud divisor.
// The receive path imports the same BAUD_DEFAULT so both directions stay at one line rate.
package uart_pkg;

    localparam int CNT_W        = 11;
    localparam int BAUD_DEFAULT = 1302;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-source handshake into the UART transmitter: word is taken on the edge where tx_valid && tx_ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..BAUDRATE-1 from a synchronous clear while run is high, no half-period preload.
// Latency: tick is high during the last clock of each bit period; no backpressure.
module uart_tx_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUDRATE = BAUD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUDRATE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || !run || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = run && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one word per handshake as start, data LSB-first, [even parity if UART_TX_PARITY_EN], stop.
// Latency: start bit drives on the accept edge; tx_ready is high in IDLE and the last stop clock, low otherwise.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUDRATE  = BAUD_DEFAULT,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave s,
    output logic     tx,
    output logic     busy
);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 rdy_en_q, rdy_en_d;
    logic                 tick;
    logic                 last_stop;
    logic                 ready;
    logic                 hs;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_tx_baud_tick #(
        .BAUDRATE (BAUDRATE)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .run   (state_q != ST_IDLE),
        .clr   (hs),
        .tick  (tick)
    );

    // Accepting in the last stop clock lets the next start bit follow with no idle gap.
    assign last_stop  = (state_q == ST_STOP) && tick && (stop_q == STOP_LAST);
    assign ready      = rdy_en_q && ((state_q == ST_IDLE) || last_stop);
    assign hs         = s.tx_valid && ready;
    assign s.tx_ready = ready;
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        tx_d     = tx_q;
        rdy_en_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (tick) begin
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                ST_DATA: begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
`endif
                ST_STOP: begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        stop_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (hs) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            shift_d = s.tx_data;
            bit_d   = '0;
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^s.tx_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
            rdy_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            tx_q     <= tx_d;
            rdy_en_q <= rdy_en_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: instances at baud 4/stop 1, baud 4/stop 2, baud 2 and baud 2047,
// each line compared every clock against a per-clock frame queue built from the frame format.
module tb_uart_tx;
    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        int         dut;
        logic [7:0] d;
        int         busy_len;
        int         rdy_low;
        int         zrun;
        bit         par;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld    [N];
    logic [7:0] dat    [N];
    logic       rdy_o  [N];
    logic       tx_o   [N];
    logic       busy_o [N];

    int n_chk  = 0;
    int n_pass = 0;
    int errs [N];
    bit rdy_en = 1'b0;
    bit expq [N][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_if #(.DATA_BITS(8)) ifc ();
        assign ifc.tx_valid = vld[g];
        assign ifc.tx_data  = dat[g];
        assign rdy_o[g]     = ifc.tx_ready;
        uart_tx #(
            .BAUDRATE  ((g == 3) ? 2047 : ((g == 2) ? 2 : 4)),
            .DATA_BITS (8),
            .STOP_BITS ((g == 1) ? 2 : 1)
        ) dut (
            .clk   (clk),
            .reset (rst_n),
            .s     (ifc),
            .tx    (tx_o[g]),
            .busy  (busy_o[g])
        );
    end

    function automatic int br_of(int i);
        return (i == 3) ? 2047 : ((i == 2) ? 2 : 4);
    endfunction

    function automatic int sb_of(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    // Line level for every clock of one frame accepted by instance i.
    function automatic void push_frame(int i, logic [7:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (P == 1) bits.push_back(^d);
        for (int k = 0; k < sb_of(i); k++) bits.push_back(1'b1);
        foreach (bits[k]) repeat (br_of(i)) expq[i].push_back(bits[k]);
    endfunction

    function automatic bit sample(bit q[$], int idx);
        return (idx < q.size()) ? q[idx] : 1'b1;
    endfunction

    // Model: a word is taken when the pending line has at most its final clock left.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) expq[i].delete();
            rdy_en = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bit hs;
                hs = vld[i] && rdy_en && (expq[i].size() <= 1);
                if (expq[i].size() != 0) void'(expq[i].pop_front());
                if (hs) push_frame(i, dat[i]);
            end
            rdy_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                bit et, eb, er;
                eb = (expq[i].size() != 0);
                et = eb ? expq[i][0] : 1'b1;
                er = rdy_en && (expq[i].size() <= 1);
                if ({tx_o[i], busy_o[i], rdy_o[i]} !== {et, eb, er}) begin
                    if (errs[i] == 0)
                        $display("dut%0d line deviates at %0t: tx/busy/rdy=%b%b%b model=%b%b%b",
                                 i, $time, tx_o[i], busy_o[i], rdy_o[i], et, eb, er);
                    errs[i]++;
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_vec(string tag, vec_t v);
        int         b, busy_n, rlow, zrun;
        bit         zdone;
        bit         line[$];
        logic [7:0] got;
        b = br_of(v.dut);
        busy_n = 0; rlow = 0; zrun = 0; zdone = 1'b0;
        @(negedge clk); #1;
        vld[v.dut] = 1'b1; dat[v.dut] = v.d;
        @(posedge clk); #1;
        vld[v.dut] = 1'b0; dat[v.dut] = 8'($urandom);
        for (int c = 0; c < 12 * b + 8; c++) begin
            @(negedge clk);
            line.push_back(tx_o[v.dut]);
            if (!busy_o[v.dut]) break;
            busy_n++;
            if (!rdy_o[v.dut]) rlow++;
            if (!zdone && !tx_o[v.dut]) zrun++;
            else zdone = 1'b1;
        end
        for (int k = 0; k < 8; k++) got[k] = sample(line, (1 + k) * b + b / 2);
        chk({tag, "_busy_len"}, busy_n, v.busy_len);
        chk({tag, "_rdy_low"}, rlow, v.rdy_low);
        chk({tag, "_start_run"}, zrun, v.zrun);
        chk({tag, "_data"}, int'(got), int'(v.d));
        chk({tag, "_stop"}, int'(sample(line, (9 + P) * b + b / 2)), 1);
`ifdef UART_TX_PARITY_EN
        chk({tag, "_parity"}, int'(sample(line, 9 * b + b / 2)), int'(v.par));
`endif
    endtask

    task automatic b2b(string tag, int i, logic [7:0] d0, logic [7:0] d1, int flen);
        int c, blow, bz;
        blow = 0; bz = 0;
        @(negedge clk); #1;
        vld[i] = 1'b1; dat[i] = d0;
        @(posedge clk); #1;
        dat[i] = d1;
        for (c = 1; c <= 4 * flen; c++) begin
            @(negedge clk);
            if (!busy_o[i]) blow++;
            if (rdy_o[i]) break;
        end
        @(posedge clk); #1;
        vld[i] = 1'b0;
        for (int k = 0; k < 4 * flen; k++) begin
            @(negedge clk);
            if (!busy_o[i]) break;
            bz++;
        end
        chk({tag, "_accept_gap"}, c, flen);
        chk({tag, "_busy_drop"}, blow, 0);
        chk({tag, "_second_len"}, bz, flen);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{0, 8'hA5, 40 + 4 * P, 39 + 4 * P, 4, 1'b0};
        vt[1] = '{0, 8'h07, 40 + 4 * P, 39 + 4 * P, 4, 1'b1};
        vt[2] = '{0, 8'h03, 40 + 4 * P, 39 + 4 * P, 4, 1'b0};
        vt[3] = '{1, 8'h55, 44 + 4 * P, 43 + 4 * P, 4, 1'b0};
        vt[4] = '{2, 8'h3C, 20 + 2 * P, 19 + 2 * P, 6, 1'b0};
        vt[5] = '{3, 8'hFF, 20470 + 2047 * P, 20469 + 2047 * P, 2047, 1'b0};
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_tx%0d", i), int'(tx_o[i]), 1);
            chk($sformatf("rst_busy%0d", i), int'(busy_o[i]), 0);
            chk($sformatf("rst_rdy%0d", i), int'(rdy_o[i]), 0);
        end
        #1 rst_n = 1'b1;
        chk("rdy_before_first_edge", int'(rdy_o[0]), 0);
        @(negedge clk);
        chk("rdy_after_first_edge", int'(rdy_o[0]), 1);

        foreach (vt[k]) apply_vec($sformatf("v%0d", k), vt[k]);

        b2b("b2b_d0", 0, 8'h00, 8'hFF, 40 + 4 * P);
        b2b("b2b_d1", 1, 8'h55, 8'hAA, 44 + 4 * P);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                vld[i] = ($urandom_range(0, 3) == 0);
                dat[i] = 8'($urandom);
            end
        end
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        repeat (80) @(negedge clk);

        // Abort a frame during data bit 3 (line low), then send a clean one.
        #1 vld[0] = 1'b1; dat[0] = 8'hF0;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("abort_pre_tx", int'(tx_o[0]), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_tx", int'(tx_o[0]), 1);
        chk("abort_busy", int'(busy_o[0]), 0);
        chk("abort_rdy", int'(rdy_o[0]), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        apply_vec("post_abort", '{0, 8'h96, 40 + 4 * P, 39 + 4 * P, 8, 1'b0});
        repeat (10) @(negedge clk);

        for (int i = 0; i < N; i++) chk($sformatf("line_dut%0d", i), errs[i], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. Serialises one data word per valid/ready handshake into an 8N1-style frame (start, data LSB-first, optional parity, stop) on a single output line.
- Contains its own bit-period counter, aligned to the frame start with no half-period offset.
- Sits between the host-side byte source and the FPGA pin. It is the transmit counterpart of the receive path, and both use the same BAUDRATE value.

Parameters:
- BAUDRATE, 1302, system clocks per bit (50 MHz / 38400 baud); legal range 2..2047.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, 50 MHz, rising edge.
- reset  input  1  reset; asynchronous, active-low.
- tx_data  input  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, tx=1, busy=0, tx_ready=0 while reset is held, bit counter=0, shift register=0.
  - tx_ready rises on the first clk edge after reset deasserts.
  - Reset mid-frame aborts the frame immediately; tx=1 with no glitch to 0.
- Handshake: a word is accepted on the clk edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - tx_data is don't-care on all other cycles.
- tx_ready is high in IDLE, and also in the final clock of the last stop bit, so back-to-back frames have zero idle gap. It is low everywhere else.
- Latency: tx falls to 0 on the same edge that accepts the word. The start bit is visible in the cycle after the handshake.
- Bit timing:
  - Every bit lasts exactly BAUDRATE clocks.
  - The counter runs 0..BAUDRATE-1, clears on handshake and wraps at BAUDRATE-1.
  - A bit boundary occurs on the wrap.
  - The counter is 11 bits wide; compare against BAUDRATE-1 in 11-bit unsigned arithmetic.
- State machine:
  - IDLE -> START on handshake.
  - START -> DATA after 1 bit.
  - DATA: shift right, tx = shift[0]. Leave after DATA_BITS bits, tracked by a bit index of 0..DATA_BITS-1 that wraps to 0 on exit.
  - DATA -> PARITY if the feature is present, else DATA -> STOP.
  - PARITY -> STOP after 1 bit.
  - STOP lasts STOP_BITS bits with tx=1. At its last clock: if a handshake occurs -> START, else -> IDLE.
- busy is high from the handshake edge until the edge that returns to IDLE. busy stays high across back-to-back frames.
- tx is driven from a register (no combinational path to the pin).
- Frame length (clocks) = BAUDRATE*(1+DATA_BITS+P+STOP_BITS), where P=1 with parity and 0 without.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after the data bits. It sends even parity (XOR of the DATA_BITS sent data bits), computed from the latched word.
- Undefined: no PARITY state and no parity logic; the frame is start, data, stop.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the counter width constant (11);
  - the default BAUDRATE constant (1302), shared with the receive path.
- One natural sub-module: uart_tx_baud_tick.
  - Counts from 0 on a synchronous clear and emits a one-clock tick at BAUDRATE-1.
  - Has no half-period preload, unlike the receive-side generator.

Test Plan:
- Single frame, BAUDRATE=4, tx_data=8'hA5, one valid pulse. Required response:
  - tx = 0 for 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), then 1;
  - busy high for exactly 40 clocks;
  - tx_ready low for 39 clocks.
- Back-to-back, BAUDRATE=4: tx_valid held high with words 8'h00 then 8'hFF.
  - The second start bit begins the clock after the first stop bit's 4th clock.
  - Total 80 clocks with no idle-high gap; busy never drops between frames.
- Parity on, BAUDRATE=4: send 8'h07, then 8'h03.
  - Parity bit is 1 for 8'h07 and 0 for 8'h03.
  - Frame is 44 clocks each.
- STOP_BITS=2, BAUDRATE=4, 8'h55: stop is high for 8 clocks; next handshake is accepted only in the last of those clocks.
- Reset asserted mid-frame (during data bit 3 with tx=0):
  - tx=1 and busy=0 asynchronously, before the next edge;
  - after release, the first frame is sent intact.
- Edge cases:
  - BAUDRATE=2047: bit period is exactly 2047 clocks (no counter overflow).
  - BAUDRATE=2: bit period is 2 clocks.
